// File: rtl/pipe_idexe_stage.sv
// ID/EXE pipeline boundary of the 5-stage pipelined computer.
// Resolves rs/rt operands by forwarding from EXE or MEM, maps shift amount,
// immediate and LUI operands onto the ALU a/b ports, detects load-use
// hazards, and registers the EXE-stage operands and controls. A taken
// branch/jump (flush) or a load-use hazard loads a bubble instead.
module pipe_idexe_stage #(
    parameter int RW = 5,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic [RW-1:0] d_rs,
    input  logic [RW-1:0] d_rt,
    input  logic [RW-1:0] d_rn,
    input  logic          d_usea,
    input  logic          d_useb,
    input  logic [DW-1:0] d_qa,
    input  logic [DW-1:0] d_qb,
    input  logic [DW-1:0] d_imm,
    input  logic [4:0]    d_sa,
    input  logic [3:0]    d_aluc,
    input  logic          d_wreg,
    input  logic          d_m2reg,
    input  logic          d_wmem,
    input  logic          d_aluimm,
    input  logic          d_shift,
    input  logic          d_lui,
    input  logic [DW-1:0] ex_alu,
    input  logic [RW-1:0] m_rn,
    input  logic          m_wreg,
    input  logic          m_m2reg,
    input  logic [DW-1:0] m_alu,
    input  logic [DW-1:0] m_mdata,
    input  logic          flush,
    output logic          stall,
    output logic [DW-1:0] e_a,
    output logic [DW-1:0] e_b,
    output logic [3:0]    e_aluc,
    output logic [DW-1:0] e_qb,
    output logic [RW-1:0] e_rn,
    output logic          e_wreg,
    output logic          e_m2reg,
    output logic          e_wmem
);

    // Registered EXE-stage state
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [3:0]    r_aluc;
    logic [DW-1:0] r_qb;
    logic [RW-1:0] r_rn;
    logic          r_wreg;
    logic          r_m2reg;
    logic          r_wmem;

    // Source index 0 is rs (feeds a), index 1 is rt (feeds b and store data)
    logic [1:0][RW-1:0] w_src;
    logic [1:0][DW-1:0] w_rf;
    logic [1:0][DW-1:0] w_fwd;
    logic [1:0]         w_ex_hit;
    logic [1:0]         w_mem_hit;
    logic [DW-1:0]      w_mem_val;
    logic [DW-1:0]      w_a;
    logic [DW-1:0]      w_b;
    logic               w_hz;
    logic               w_bubble;

    assign w_src[0] = d_rs;
    assign w_src[1] = d_rt;
    assign w_rf[0]  = d_qa;
    assign w_rf[1]  = d_qb;

    // A load in MEM hands over its loaded data; anything else its ALU result
    assign w_mem_val = m_m2reg ? m_mdata : m_alu;

    // Per-source forwarding. r0 is hardwired zero, so it never forwards.
    // A load still in EXE has no data yet; that case is covered by the stall.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign w_ex_hit[gi]  = (w_src[gi] != '0) && r_wreg && !r_m2reg &&
                                   (w_src[gi] == r_rn);
            assign w_mem_hit[gi] = (w_src[gi] != '0) && m_wreg &&
                                   (w_src[gi] == m_rn);
            assign w_fwd[gi]     = w_ex_hit[gi]  ? ex_alu    :
                                   w_mem_hit[gi] ? w_mem_val : w_rf[gi];
        end
    endgenerate

    // LUI passes the immediate through a (the ALU does the shift by 16)
    assign w_a = d_lui   ? d_imm :
                 d_shift ? {{(DW-5){1'b0}}, d_sa} : w_fwd[0];
    assign w_b = d_aluimm ? d_imm : w_fwd[1];

    // Load-use: the load in EXE targets a register the ID instruction reads
    assign w_hz = r_m2reg && r_wreg && (r_rn != '0) &&
                  ((d_usea && (d_rs == r_rn)) || (d_useb && (d_rt == r_rn)));

    // A flushed instruction is dead anyway, so there is nothing to hold back
    assign stall    = w_hz && !flush;
    assign w_bubble = w_hz || flush;

    // ID/EXE register: a bubble is all zeros, i.e. ADD 0+0 with no write
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_a     <= '0;
            r_b     <= '0;
            r_aluc  <= '0;
            r_qb    <= '0;
            r_rn    <= '0;
            r_wreg  <= 1'b0;
            r_m2reg <= 1'b0;
            r_wmem  <= 1'b0;
        end else if (w_bubble) begin
            r_a     <= '0;
            r_b     <= '0;
            r_aluc  <= '0;
            r_qb    <= '0;
            r_rn    <= '0;
            r_wreg  <= 1'b0;
            r_m2reg <= 1'b0;
            r_wmem  <= 1'b0;
        end else begin
            r_a     <= w_a;
            r_b     <= w_b;
            r_aluc  <= d_aluc;
            r_qb    <= w_fwd[1];
            r_rn    <= d_rn;
            r_wreg  <= d_wreg;
            r_m2reg <= d_m2reg;
            r_wmem  <= d_wmem;
        end
    end

    assign e_a     = r_a;
    assign e_b     = r_b;
    assign e_aluc  = r_aluc;
    assign e_qb    = r_qb;
    assign e_rn    = r_rn;
    assign e_wreg  = r_wreg;
    assign e_m2reg = r_m2reg;
    assign e_wmem  = r_wmem;

endmodule

// File: tb/tb_pipe_idexe_stage.sv
// Testbench for pipe_idexe_stage: directed scenarios plus random traffic,
// checked by a scoreboard fed from an instruction-level reference model.
module tb_pipe_idexe_stage;

    logic        clock = 1'b0;
    logic        resetn;
    logic [4:0]  d_rs, d_rt, d_rn, d_sa, m_rn;
    logic        d_usea, d_useb, d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_lui;
    logic [31:0] d_qa, d_qb, d_imm, ex_alu, m_alu, m_mdata;
    logic [3:0]  d_aluc;
    logic        m_wreg, m_m2reg, flush;
    logic        stall;
    logic [31:0] e_a, e_b, e_qb;
    logic [3:0]  e_aluc;
    logic [4:0]  e_rn;
    logic        e_wreg, e_m2reg, e_wmem;

    pipe_idexe_stage #(.RW(5), .DW(32)) dut (
        .clock(clock), .resetn(resetn),
        .d_rs(d_rs), .d_rt(d_rt), .d_rn(d_rn), .d_usea(d_usea), .d_useb(d_useb),
        .d_qa(d_qa), .d_qb(d_qb), .d_imm(d_imm), .d_sa(d_sa), .d_aluc(d_aluc),
        .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_wmem(d_wmem), .d_aluimm(d_aluimm),
        .d_shift(d_shift), .d_lui(d_lui), .ex_alu(ex_alu),
        .m_rn(m_rn), .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_alu(m_alu),
        .m_mdata(m_mdata), .flush(flush), .stall(stall),
        .e_a(e_a), .e_b(e_b), .e_aluc(e_aluc), .e_qb(e_qb), .e_rn(e_rn),
        .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem)
    );

    always #5 clock = ~clock;

    // Contents of the EXE stage, as an instruction
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  aluc;
        logic [31:0] qb;
        logic [4:0]  rn;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
    } exe_t;

    typedef struct packed {
        logic stall;   // expected stall while these ID inputs are presented
        exe_t e;       // expected EXE contents after the following edge
    } item_t;

    item_t sb_q[$];
    exe_t  mdl;        // model's view of what currently sits in EXE
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Value register x holds as the ID instruction should see it: the newest
    // in-flight producer wins; r0 is always the regfile value.
    function automatic logic [31:0] see_reg(input logic [4:0] x, input logic [31:0] rf);
        if (x == 5'd0) return rf;
        if (mdl.wreg && !mdl.m2reg && mdl.rn == x) return ex_alu;
        if (m_wreg && m_rn == x) return m_m2reg ? m_mdata : m_alu;
        return rf;
    endfunction

    function automatic logic load_use();
        if (!(mdl.wreg && mdl.m2reg) || mdl.rn == 5'd0) return 1'b0;
        return (d_usea && d_rs == mdl.rn) || (d_useb && d_rt == mdl.rn);
    endfunction

    // Compute the expected outcome of the current ID inputs and advance one cycle
    task automatic step();
        item_t it;
        exe_t  nx;
        logic  hz;
        hz = load_use();
        nx = '0;
        if (!hz && !flush) begin
            nx.a     = d_lui ? d_imm : (d_shift ? 32'(d_sa) : see_reg(d_rs, d_qa));
            nx.b     = d_aluimm ? d_imm : see_reg(d_rt, d_qb);
            nx.aluc  = d_aluc;
            nx.qb    = see_reg(d_rt, d_qb);
            nx.rn    = d_rn;
            nx.wreg  = d_wreg;
            nx.m2reg = d_m2reg;
            nx.wmem  = d_wmem;
        end
        it.stall = hz && !flush;
        it.e     = nx;
        sb_q.push_back(it);
        @(posedge clock);
        mdl = nx;
        #2;
    endtask

    task automatic idle_inputs();
        d_rs = 0; d_rt = 0; d_rn = 0; d_sa = 0; d_usea = 0; d_useb = 0;
        d_qa = 0; d_qb = 0; d_imm = 0; d_aluc = 0; d_wreg = 0; d_m2reg = 0;
        d_wmem = 0; d_aluimm = 0; d_shift = 0; d_lui = 0; ex_alu = 0;
        m_rn = 0; m_wreg = 0; m_m2reg = 0; m_alu = 0; m_mdata = 0; flush = 0;
    endtask

    // Monitor: stall checked mid-cycle, registered outputs just after the edge
    initial begin
        item_t it;
        forever begin
            @(negedge clock);
            if (sb_q.size() > 0) begin
                chk("sb_stall", 32'(stall), 32'(sb_q[0].stall));
                @(posedge clock);
                #1;
                it = sb_q.pop_front();
                chk("sb_e_a", e_a, it.e.a);
                chk("sb_e_b", e_b, it.e.b);
                chk("sb_e_aluc", 32'(e_aluc), 32'(it.e.aluc));
                chk("sb_e_qb", e_qb, it.e.qb);
                chk("sb_e_rn", 32'(e_rn), 32'(it.e.rn));
                chk("sb_e_wreg", 32'(e_wreg), 32'(it.e.wreg));
                chk("sb_e_m2reg", 32'(e_m2reg), 32'(it.e.m2reg));
                chk("sb_e_wmem", 32'(e_wmem), 32'(it.e.wmem));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        mdl = '0;
        resetn = 1'b0;
        // Reset with busy inputs: outputs must stay clear
        d_rs = 5'd1; d_rt = 5'd2; d_rn = 5'd9; d_sa = 5'd3; d_usea = 1; d_useb = 1;
        d_qa = 32'h11; d_qb = 32'h22; d_imm = 32'h33; d_aluc = 4'd2; d_wreg = 1;
        d_m2reg = 0; d_wmem = 0; d_aluimm = 0; d_shift = 0; d_lui = 0;
        ex_alu = 32'h44; m_rn = 5'd1; m_wreg = 0; m_m2reg = 0; m_alu = 32'h55;
        m_mdata = 32'h66; flush = 0;
        repeat (3) @(posedge clock);
        #2;
        chk("rst_e_a", e_a, 32'h0);
        chk("rst_e_rn", 32'(e_rn), 32'h0);
        chk("rst_e_wreg", 32'(e_wreg), 32'h0);
        chk("rst_e_aluc", 32'(e_aluc), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        resetn = 1'b1;

        // First edge after release loads the ID values
        step();
        chk("first_e_a", e_a, 32'h11);
        chk("first_e_rn", 32'(e_rn), 32'd9);

        // EXE-to-EXE forward, and r0 never forwards
        idle_inputs(); d_rn = 5'd5; d_wreg = 1; step();
        idle_inputs(); d_rs = 5'd5; d_usea = 1; d_qa = 32'h9; ex_alu = 32'h1234;
        d_rn = 5'd5; d_wreg = 1; step();
        chk("fwd_ex", e_a, 32'h1234);
        idle_inputs(); d_rs = 5'd0; d_usea = 1; d_qa = 32'h9; ex_alu = 32'h1234; step();
        chk("fwd_r0", e_a, 32'h9);

        // Forward priority: EXE over MEM, then MEM ALU, then MEM load data
        idle_inputs(); d_rn = 5'd7; d_wreg = 1; step();
        idle_inputs(); d_rs = 5'd7; d_usea = 1; ex_alu = 32'hA; m_rn = 5'd7;
        m_wreg = 1; m_alu = 32'hB; m_mdata = 32'hC; d_rn = 5'd8; d_wreg = 1; step();
        chk("prio_ex", e_a, 32'hA);
        step();
        chk("prio_mem_alu", e_a, 32'hB);
        m_m2reg = 1; step();
        chk("prio_mem_load", e_a, 32'hC);

        // Load-use: one stall, a bubble, then the data arrives from MEM
        idle_inputs(); d_rn = 5'd3; d_wreg = 1; d_m2reg = 1; step();
        idle_inputs(); d_rt = 5'd3; d_useb = 1; d_rn = 5'd4; d_wreg = 1; d_qb = 32'h55;
        #1;
        chk("lu_stall", 32'(stall), 32'h1);
        step();
        chk("lu_bubble_wreg", 32'(e_wreg), 32'h0);
        m_rn = 5'd3; m_wreg = 1; m_m2reg = 1; m_mdata = 32'hDEADBEEF;
        #1;
        chk("lu_stall_gone", 32'(stall), 32'h0);
        step();
        chk("lu_e_b", e_b, 32'hDEADBEEF);
        chk("lu_e_wreg", 32'(e_wreg), 32'h1);

        // Operand mapping: sll, lui, addi
        idle_inputs(); d_shift = 1; d_sa = 5'd4; d_rt = 5'd2; d_useb = 1; d_qb = 32'h77;
        d_rs = 5'd9; d_qa = 32'h99; step();
        chk("sll_e_a", e_a, 32'h4);
        chk("sll_e_b", e_b, 32'h77);
        idle_inputs(); d_lui = 1; d_imm = 32'h0000ABCD; d_qa = 32'h1; step();
        chk("lui_e_a", e_a, 32'h0000ABCD);
        idle_inputs(); d_aluimm = 1; d_imm = 32'hFFFFFFFF; d_qb = 32'h2; step();
        chk("addi_e_b", e_b, 32'hFFFFFFFF);

        // Flush together with a load-use hazard
        idle_inputs(); d_rn = 5'd3; d_wreg = 1; d_m2reg = 1; step();
        idle_inputs(); d_rs = 5'd3; d_usea = 1; d_wreg = 1; d_rn = 5'd6; flush = 1;
        #1;
        chk("flush_stall", 32'(stall), 32'h0);
        step();
        chk("flush_e_wreg", 32'(e_wreg), 32'h0);
        chk("flush_e_rn", 32'(e_rn), 32'h0);

        // Store data forwarded from MEM
        idle_inputs(); d_wmem = 1; d_rt = 5'd6; d_useb = 1; d_qb = 32'h1;
        m_rn = 5'd6; m_wreg = 1; m_alu = 32'h600D; step();
        chk("sw_e_qb", e_qb, 32'h600D);
        chk("sw_e_wmem", 32'(e_wmem), 32'h1);

        // Reset asserted while stalled
        idle_inputs(); d_rn = 5'd3; d_wreg = 1; d_m2reg = 1; d_aluc = 4'd5; step();
        idle_inputs(); d_rt = 5'd3; d_useb = 1;
        #1;
        chk("mid_stall", 32'(stall), 32'h1);
        resetn = 1'b0;
        #1;
        mdl = '0;
        chk("mid_rst_m2reg", 32'(e_m2reg), 32'h0);
        chk("mid_rst_aluc", 32'(e_aluc), 32'h0);
        chk("mid_rst_stall", 32'(stall), 32'h0);
        resetn = 1'b1;

        // Random traffic over a small register set so hazards are frequent
        for (int n = 0; n < 400; n++) begin
            d_rs = 5'($urandom_range(0, 3)); d_rt = 5'($urandom_range(0, 3));
            d_rn = 5'($urandom_range(0, 3)); m_rn = 5'($urandom_range(0, 3));
            d_usea = 1'($urandom); d_useb = 1'($urandom);
            d_wreg = 1'($urandom); d_m2reg = ($urandom_range(0, 2) == 0);
            d_wmem = ($urandom_range(0, 3) == 0);
            d_aluimm = ($urandom_range(0, 3) == 0);
            d_shift = ($urandom_range(0, 5) == 0);
            d_lui = ($urandom_range(0, 5) == 0);
            d_sa = 5'($urandom); d_aluc = 4'($urandom);
            d_qa = $urandom; d_qb = $urandom; d_imm = $urandom;
            ex_alu = $urandom; m_alu = $urandom; m_mdata = $urandom;
            m_wreg = 1'($urandom); m_m2reg = 1'($urandom);
            flush = ($urandom_range(0, 7) == 0);
            step();
        end

        // Let the monitor drain, bounded
        for (int w = 0; w < 20 && sb_q.size() > 0; w++) @(posedge clock);
        if (sb_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d items left, required 0", sb_q.size());
        end
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
